// File: rtl/full_handshake_rx.sv
// Receive side of a four-phase req/ack handshake crossing into the clk domain.
// Captures one payload per exchange and presents it on a valid/ready interface.
module full_handshake_rx #(
    parameter int DATA_WIDTH = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hs_vld,
    input  logic [DATA_WIDTH-1:0] hs_data,
    output logic                  hs_rdy,
    output logic                  o_vld,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_rdy
);

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        DELIVER = 3'b010,
        ACK     = 3'b100
    } state_t;

    state_t                state, state_nx;
    logic                  vld_meta, vld_s;
    logic                  o_vld_nx, hs_rdy_nx;
    logic [DATA_WIDTH-1:0] o_data_nx;

    // hs_vld is asynchronous; only vld_s may be used by the FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_meta <= 1'b0;
            vld_s    <= 1'b0;
        end else begin
            vld_meta <= hs_vld;
            vld_s    <= vld_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            o_vld  <= 1'b0;
            hs_rdy <= 1'b0;
            o_data <= '0;
        end else begin
            state  <= state_nx;
            o_vld  <= o_vld_nx;
            hs_rdy <= hs_rdy_nx;
            o_data <= o_data_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        o_vld_nx  = o_vld;
        hs_rdy_nx = hs_rdy;
        o_data_nx = o_data;
        case (state)
            IDLE: begin
                if (vld_s) begin
                    o_data_nx = hs_data;
                    o_vld_nx  = 1'b1;
                    state_nx  = DELIVER;
                end
            end
            DELIVER: begin
                if (o_vld && i_rdy) begin
                    o_vld_nx  = 1'b0;
                    hs_rdy_nx = 1'b1;
                    state_nx  = ACK;
                end
            end
            ACK: begin
                // ack is held until the transmitter withdraws its request
                if (!vld_s) begin
                    hs_rdy_nx = 1'b0;
                    state_nx  = IDLE;
                end
            end
            default: begin
                o_vld_nx  = 1'b0;
                hs_rdy_nx = 1'b0;
                state_nx  = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_full_handshake_rx.sv
// Bench for full_handshake_rx: vector table of four-phase exchanges, hand-written
// corner sequences, and a randomised run with a separate transmitter clock.
`timescale 1ns/1ps
module tb_full_handshake_rx;

    localparam int DW = 40;

    logic          clk = 1'b0;
    logic          tx_clk = 1'b0;
    logic          rst;
    logic          hs_vld;
    logic [DW-1:0] hs_data;
    logic          hs_rdy;
    logic          o_vld;
    logic [DW-1:0] o_data;
    logic          i_rdy;

    real           tx_half = 15.0;

    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    int unsigned   rd    = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   rdy_wait;
        logic [DW-1:0] exp_data;
        int unsigned   exp_lat;
    } vec_t;

    vec_t vecs[6];

    full_handshake_rx #(.DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .hs_vld  (hs_vld),
        .hs_data (hs_data),
        .hs_rdy  (hs_rdy),
        .o_vld   (o_vld),
        .o_data  (o_data),
        .i_rdy   (i_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #2.3;
        forever #(tx_half) tx_clk = ~tx_clk;
    end

    // every accepted downstream transfer is recorded; inputs change at posedge+1
    always @(negedge clk) begin
        if (!rst && o_vld && i_rdy) got_q.push_back(o_data);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check();
        check("sb_count", 64'(got_q.size()), 64'(exp_q.size()));
        while (rd < exp_q.size()) begin
            if (rd < got_q.size()) check("sb_data", 64'(got_q[rd]), 64'(exp_q[rd]));
            rd++;
        end
    endtask

    task automatic exchange(input vec_t v);
        int unsigned lat;
        int unsigned n;
        i_rdy   = (v.rdy_wait == 0);
        hs_data = v.data;
        hs_vld  = 1'b1;
        exp_q.push_back(v.exp_data);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!o_vld && lat < 20);
        check("latency", 64'(lat), 64'(v.exp_lat));
        check("rdy_before_accept", 64'(hs_rdy), 64'h0);
        for (int unsigned k = 0; k < v.rdy_wait; k++) begin
            tick();
            check("bp_vld", 64'(o_vld), 64'h1);
            check("bp_data", 64'(o_data), 64'(v.exp_data));
            check("bp_rdy", 64'(hs_rdy), 64'h0);
        end
        i_rdy = 1'b1;
        tick();
        check("vld_after_accept", 64'(o_vld), 64'h0);
        check("rdy_after_accept", 64'(hs_rdy), 64'h1);
        i_rdy = 1'b0;
        for (int unsigned k = 0; k < 2; k++) begin
            tick();
            check("ack_hold_rdy", 64'(hs_rdy), 64'h1);
            check("ack_no_recapture", 64'(o_vld), 64'h0);
        end
        hs_vld = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (hs_rdy && n < 10);
        check("rdy_release_cycles", 64'(n), 64'h3);
        check("hold_data", 64'(o_data), 64'(v.exp_data));
        sb_check();
    endtask

    initial begin
        int unsigned n;
        bit          tx_timeout;
        bit          tx_done;
        logic [DW-1:0] pay;

        vecs[0] = '{40'h12_3456_789A, 0,  40'h12_3456_789A, 3};
        vecs[1] = '{40'hC0_FFEE_1234, 10, 40'hC0_FFEE_1234, 3};
        vecs[2] = '{40'h00_0000_0000, 0,  40'h00_0000_0000, 3};
        vecs[3] = '{40'h00_0000_0001, 0,  40'h00_0000_0001, 3};
        vecs[4] = '{40'hFF_FFFF_FFFF, 0,  40'hFF_FFFF_FFFF, 3};
        vecs[5] = '{40'hA5_A5A5_A5A5, 0,  40'hA5_A5A5_A5A5, 3};

        rst = 1'b1; hs_vld = 1'b0; hs_data = '0; i_rdy = 1'b0;
        #3;
        check("rst_vld", 64'(o_vld), 64'h0);
        check("rst_rdy", 64'(hs_rdy), 64'h0);
        check("rst_data", 64'(o_data), 64'h0);
        tick(); tick();
        rst = 1'b0;
        for (int unsigned k = 0; k < 4; k++) tick();
        check("no_spurious_vld", 64'(o_vld), 64'h0);

        for (int unsigned i = 0; i < 6; i++) exchange(vecs[i]);

        // protocol violation: request withdrawn while the payload is still pending
        i_rdy = 1'b0; hs_data = 40'h3C_3C3C_0001; hs_vld = 1'b1;
        exp_q.push_back(40'h3C_3C3C_0001);
        n = 0;
        do begin tick(); n++; end while (!o_vld && n < 20);
        hs_vld = 1'b0;
        for (int unsigned k = 0; k < 4; k++) tick();
        check("viol_vld_held", 64'(o_vld), 64'h1);
        check("viol_data_held", 64'(o_data), 64'h3C_3C3C_0001);
        i_rdy = 1'b1;
        tick();
        check("viol_rdy_up", 64'(hs_rdy), 64'h1);
        check("viol_vld_down", 64'(o_vld), 64'h0);
        i_rdy = 1'b0;
        tick();
        check("viol_rdy_down", 64'(hs_rdy), 64'h0);
        check("viol_idle", 64'(dut.state), 64'h1);
        sb_check();

        // reset while a payload waits downstream
        hs_data = 40'h5A_5A0F_0F33; hs_vld = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!o_vld && n < 20);
        check("pre_rst_vld", 64'(o_vld), 64'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_vld", 64'(o_vld), 64'h0);
        check("async_rst_rdy", 64'(hs_rdy), 64'h0);
        check("async_rst_data", 64'(o_data), 64'h0);
        check("async_rst_state", 64'(dut.state), 64'h1);
        hs_vld = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int unsigned k = 0; k < 6; k++) tick();
        check("post_rst_vld", 64'(o_vld), 64'h0);
        sb_check();

        // random downstream ready with slow (1:3) then fast (3:1) transmitter clock
        for (int unsigned r = 0; r < 2; r++) begin
            tx_half = (r == 0) ? 15.0 : 1.667;
            tx_timeout = 1'b0;
            tx_done = 1'b0;
            fork
                begin
                    for (int unsigned t = 0; t < 12; t++) begin
                        pay = {$urandom, $urandom};
                        @(posedge tx_clk);
                        hs_data = pay;
                        hs_vld = 1'b1;
                        exp_q.push_back(pay);
                        n = 0;
                        while (!hs_rdy && n < 3000) begin @(posedge tx_clk); n++; end
                        if (n >= 3000) tx_timeout = 1'b1;
                        hs_vld = 1'b0;
                        n = 0;
                        while (hs_rdy && n < 3000) begin @(posedge tx_clk); n++; end
                        if (n >= 3000) tx_timeout = 1'b1;
                    end
                    tx_done = 1'b1;
                end
                begin
                    while (!tx_done) begin
                        tick();
                        i_rdy = 1'($urandom_range(0, 1));
                    end
                end
            join
            i_rdy = 1'b0;
            for (int unsigned k = 0; k < 4; k++) tick();
            check("rand_timeout", 64'(tx_timeout), 64'h0);
            sb_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/full_handshake_rx.md
FULL_HANDSHAKE_RX -- requirements
Module: full_handshake_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DATA_WIDTH, default 40, SHALL set the width of the payload.
REQ-003 Port clk  input  1  SHALL be the receive-domain clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the asynchronous active-high reset.
REQ-005 Port hs_vld  input  1  SHALL be the request from the four-phase transmitter; it is asynchronous to clk.
REQ-006 Port hs_data  input  DATA_WIDTH  SHALL be the transmitter payload; it is stable while hs_vld is high.
REQ-007 Port hs_rdy  output  1  SHALL be the acknowledge returned to the transmitter; it is registered and glitch-free.
REQ-008 Port o_vld  output  1  SHALL be the valid signal for the downstream consumer in the clk domain.
REQ-009 Port o_data  output  DATA_WIDTH  SHALL be the payload presented to the downstream consumer.
REQ-010 Port i_rdy  input  1  SHALL be the downstream ready; a transfer occurs on a cycle where o_vld && i_rdy.

Function
REQ-011 hs_vld SHALL pass through a 2-flop synchronizer (vld_s); no other logic samples hs_vld directly.
REQ-012 hs_data SHALL NOT be synchronized; it is sampled only in a cycle where vld_s=1 and the state is IDLE.
REQ-013 The FSM SHALL be one-hot with three states: IDLE=3'b001, DELIVER=3'b010, ACK=3'b100.
REQ-014 In IDLE with vld_s=1, the block SHALL load o_data<=hs_data, set o_vld<=1 and go to DELIVER; with vld_s=0 it SHALL stay in IDLE with outputs unchanged.
REQ-015 In DELIVER, o_vld SHALL stay 1 and o_data SHALL stay stable until o_vld && i_rdy.
REQ-016 On that acceptance cycle, the block SHALL set o_vld<=0 and hs_rdy<=1 and go to ACK.
REQ-017 In ACK, hs_rdy SHALL stay 1 while vld_s=1.
REQ-018 In ACK with vld_s=0, the block SHALL set hs_rdy<=0 and go to IDLE.
REQ-019 o_data SHALL hold the last captured payload outside DELIVER; it is never cleared except by reset.
REQ-020 hs_rdy SHALL be asserted only after downstream acceptance; this gives end-to-end backpressure to the transmitter.
REQ-021 Latency: with hs_vld rising before clk edge E0, vld_s=1 after E1 and o_vld=1 after E2.
REQ-022 With i_rdy held at 1, o_vld SHALL be high for exactly one cycle and hs_rdy SHALL rise at the same edge o_vld falls.
REQ-023 Each four-phase exchange SHALL produce exactly one o_vld transfer; a vld_s still high on re-entry to IDLE is impossible by construction.
REQ-024 Protocol violation, vld_s falling while in DELIVER: delivery SHALL complete normally; ACK then sees vld_s=0 and returns to IDLE after one cycle of hs_rdy=1.
REQ-025 A new request SHALL be accepted only from IDLE; a vld_s high seen in ACK SHALL NOT start a second capture.
REQ-026 Any non-one-hot state value SHALL transition to IDLE with o_vld<=0 and hs_rdy<=0.
REQ-027 i_rdy SHALL be ignored outside DELIVER.

Reset
REQ-028 While rst=1, the block SHALL hold state=IDLE, both synchronizer flops=0, o_vld=0, o_data=0 and hs_rdy=0, independent of clk.
REQ-029 Reset asserted mid-transfer SHALL discard the transfer; the transmitter is reset in the same reset domain.
REQ-030 After rst deasserts, the block SHALL act on hs_vld only through the synchronizer; there is no spurious o_vld pulse.

Verification
REQ-031 Single transfer, i_rdy=1: hs_data=40'h12_3456_789A, raise hs_vld -> o_vld=1 for exactly one cycle, 2 edges after the first sampling edge, o_data=40'h12_3456_789A; hs_rdy rises; drop hs_vld -> hs_rdy=0 within 3 cycles.
REQ-032 Backpressure: i_rdy=0 for 10 cycles after o_vld rises -> o_vld and o_data held and hs_rdy=0 throughout; i_rdy=1 -> one transfer, then hs_rdy=1.
REQ-033 Back-to-back: 4 exchanges with payloads 0,1,FF..FF,A5A5A5A5A5 -> exactly 4 o_vld transfers in order; no duplicates.
REQ-034 Reset mid-DELIVER: assert rst while o_vld=1 -> o_vld, hs_rdy and o_data are 0 immediately (asynchronous); FSM is in IDLE.
REQ-035 Violation: drop hs_vld while in DELIVER, then i_rdy=1 -> one transfer; hs_rdy high for one cycle; FSM returns to IDLE.
REQ-036 Random i_rdy with a tx clock ratio of 1:3 and 3:1 -> scoreboard shows every payload delivered once, in order.
